wb_bus_initiator: RTL and testbench
===================================

WB_BUS_INITIATOR -- requirements
Module: wb_bus_initiator

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, is the bus cycles without ack before abort (1..255).
REQ-002 wb_clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  the block can accept a command.
REQ-006 cmd_we  input  1  1 = write, 0 = read.
REQ-007 cmd_sel  input  4  byte selects.
REQ-008 cmd_adr  input  32  byte address.
REQ-009 cmd_dat  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_dat  output  32  read data; 0 for writes and errors.
REQ-012 rsp_err  output  1  transaction aborted by timeout; valid with rsp_valid.
REQ-013 wbm_cyc_o, wbm_stb_o  output  1 each  Wishbone cycle and strobe.
REQ-014 wbm_we_o  output  1  write enable.
REQ-015 wbm_sel_o  output  4  byte selects.
REQ-016 wbm_adr_o  output  32  address.
REQ-017 wbm_dat_o  output  32  write data.
REQ-018 wbm_ack_i  input  1  responder acknowledge.
REQ-019 wbm_dat_i  input  32  responder read data.

Function
REQ-020 The FSM SHALL have states IDLE, BUS and RESP.
REQ-021 In IDLE, cmd_ready SHALL be 1. In BUS and RESP it SHALL be 0.
REQ-022 On cmd_valid && cmd_ready, the block SHALL register we/sel/adr/dat onto the wbm_* outputs and enter BUS.
- wbm_cyc_o and wbm_stb_o go to 1 on that same edge, so bus latency from the accept is 1 cycle.
REQ-023 In BUS, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL stay stable until the transaction ends.
REQ-024 When wbm_ack_i is sampled 1 in BUS, the block SHALL:
- drop wbm_cyc_o and wbm_stb_o on that edge;
- capture wbm_dat_i into rsp_dat for a read, or 0 for a write;
- set rsp_err=0 and enter RESP.
REQ-025 In RESP, rsp_valid SHALL be 1 for exactly one cycle, after which the FSM returns to IDLE.
- There is no response backpressure.
- Ack-to-rsp_valid latency is 1 cycle; minimum command-to-command spacing is 3 cycles.
REQ-026 wbm_ack_i SHALL be ignored outside BUS, including an ack held high into the cycle after cyc drops.
REQ-027 While rsp_valid=0, rsp_dat and rsp_err SHALL hold their last values.
REQ-028 wbm_we_o, wbm_sel_o, wbm_adr_o and wbm_dat_o SHALL hold their last values in IDLE.

Reset
REQ-029 On wb_rst_i=1, regardless of the clock, the FSM SHALL go to IDLE and all outputs SHALL clear to 0, except cmd_ready, which is 1 in IDLE.
REQ-030 Reset during BUS SHALL abort the transaction with no rsp_valid pulse; cyc and stb drop immediately.
REQ-031 Reset release SHALL take effect at the first clock edge after deassertion; no command is accepted while wb_rst_i=1.

Configuration
REQ-032 Macro WB_INITIATOR_TIMEOUT_EN SHALL control the timeout feature.
REQ-033 With WB_INITIATOR_TIMEOUT_EN defined:
- an 8-bit counter clears on entry to BUS and increments on each BUS cycle without ack;
- when the counter equals TIMEOUT_CYCLES and ack=0, the block drops cyc/stb, sets rsp_dat=0 and rsp_err=1, and enters RESP;
- if ack and the timeout occur in the same cycle, ack wins and rsp_err=0.
REQ-034 Without WB_INITIATOR_TIMEOUT_EN, no counter SHALL exist, BUS waits indefinitely for ack, and rsp_err SHALL be constant 0.

Verification
REQ-035 Write: cmd adr=0x30000000, dat=0x00000003, sel=0xF, we=1; responder acks on the 2nd BUS cycle -> wbm_adr_o=0x30000000, wbm_we_o=1 held stable; rsp_valid one pulse with rsp_dat=0 and rsp_err=0.
REQ-036 Read: cmd adr=0x30000000, we=0; responder returns 0x00000003 with ack -> rsp_dat=0x00000003 and rsp_err=0, one cycle after ack.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=4): read to 0x30000FF0 and never ack -> cyc drops after 5 BUS cycles; rsp_err=1 and rsp_dat=0.
REQ-038 Ack and timeout in the same cycle (TIMEOUT_CYCLES=4): ack on the 5th BUS cycle with wbm_dat_i=0xA5A5A5A5 -> rsp_dat=0xA5A5A5A5 and rsp_err=0.
REQ-039 Reset mid-BUS: assert wb_rst_i between clock edges -> cyc/stb drop without waiting for a clock edge; no rsp_valid pulse; after release, cmd_ready=1 and a new command completes normally.
REQ-040 Back-to-back: cmd_valid held high with two commands, responder acking for 2 cycles -> second accept occurs only after the first rsp_valid; the stale ack is ignored; two rsp_valid pulses.

Source files
------------

// File: rtl/wb_bus_initiator.sv
// Single-transaction Wishbone initiator: accepts one command, runs one bus cycle, returns one response.
// Optional abort-on-no-ack watchdog enabled by defining WB_INITIATOR_TIMEOUT_EN.
module wb_bus_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [3:0]  cmd_sel,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  output logic        rsp_valid,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_r;

  if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd255)) begin : g_bad_timeout
    $error("wb_bus_initiator: TIMEOUT_CYCLES must be in 1..255");
  end

`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
  logic [7:0] timeout_cnt_r;
  logic       rsp_err_r;
  assign rsp_err = rsp_err_r;
`else
  assign rsp_err = 1'b0;
`endif

  // Control FSM; every output is a register updated here. Ack is only looked at in BUS.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r   <= IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'h0000_0000;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= 32'h0000_0000;
      wbm_dat_o <= 32'h0000_0000;
`ifdef WB_INITIATOR_TIMEOUT_EN
      timeout_cnt_r <= 8'd0;
      rsp_err_r     <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            state_r   <= BUS;
`ifdef WB_INITIATOR_TIMEOUT_EN
            timeout_cnt_r <= 8'd0;
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= wbm_we_o ? 32'h0000_0000 : wbm_dat_i;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
`ifdef WB_INITIATOR_TIMEOUT_EN
            rsp_err_r <= 1'b0;
          end else if (timeout_cnt_r == TIMEOUT_LIMIT) begin
            // Ack has priority over the watchdog when both land in the same cycle.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_dat   <= 32'h0000_0000;
            rsp_err_r <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RESP;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + 8'd1;
            state_r       <= BUS;
          end
`else
          end else begin
            state_r <= BUS;
          end
`endif
        end
        RESP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_bus_initiator.sv
// Self-checking bench for wb_bus_initiator: directed scenarios plus randomized transactions
// scored against a transaction-level model (bus length, response data, error flag).
module tb_wb_bus_initiator;

  localparam int TMO = 4;
`ifdef WB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_adr, cmd_dat;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;

  int checks = 0;
  int failures = 0;

  wb_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_sel  (cmd_sel),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
  );

  always #5 clk = ~clk;

  // Model: bus length in cycles given the cycle on which the responder acks (0 = never).
  function automatic int exp_bus_cycles(input int ack_on);
    if (TO_EN && (ack_on < 1 || ack_on > TMO + 1)) return TMO + 1;
    return ack_on;
  endfunction

  // Drives one command and a responder that acks on BUS cycle ack_on; returns observations only.
  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                         input int ack_on, input logic [31:0] rdata,
                         output int bus_cycles, output bit fields_ok, output bit resp_now,
                         output logic [31:0] r_dat, output logic r_err, output bit one_pulse, output bit hold_ok);
    int k;
    cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
    k = 0;
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = ~we; cmd_sel = 4'($urandom); cmd_adr = $urandom; cmd_dat = $urandom;
    fields_ok = 1'b1;
    bus_cycles = 0;
    while (wbm_cyc_o && bus_cycles < 300) begin
      bus_cycles++;
      if (!(wbm_stb_o === 1'b1 && wbm_we_o === we && wbm_sel_o === sel &&
            wbm_adr_o === adr && wbm_dat_o === dat)) fields_ok = 1'b0;
      wbm_ack_i = (bus_cycles == ack_on);
      wbm_dat_i = wbm_ack_i ? rdata : $urandom;
      @(posedge clk); #1;
    end
    wbm_ack_i = 1'b0;
    resp_now = rsp_valid;
    r_dat = rsp_dat;
    r_err = rsp_err;
    @(posedge clk); #1;
    one_pulse = (rsp_valid === 1'b0) && (cmd_ready === 1'b1);
    hold_ok = (rsp_dat === r_dat) && (rsp_err === r_err) && (wbm_adr_o === adr) &&
              (wbm_we_o === we) && (wbm_sel_o === sel) && (wbm_dat_o === dat) && (wbm_cyc_o === 1'b0);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    checks++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid, rsp_err}); end
    checks++; if ({rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 100'b0) begin
      failures++; $display("FAIL reset_data got=%h/%h/%h/%h exp=0", rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o); end
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (wbm_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_no_accept got=%b exp=0", wbm_cyc_o); end
    cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int bc; bit fo, rn, op, ho; logic [31:0] d; logic e;
    run_txn(1'b1, 4'hF, 32'h3000_0000, 32'h0000_0003, 2, $urandom, bc, fo, rn, d, e, op, ho);
    checks++; if (bc !== 2) begin failures++; $display("FAIL write_bus_cycles got=%0d exp=2", bc); end
    checks++; if (!fo) begin failures++; $display("FAIL write_fields_stable got=0 exp=1"); end
    checks++; if (!rn || d !== 32'h0 || e !== 1'b0) begin
      failures++; $display("FAIL write_rsp got=v%b d%h e%b exp=v1 d00000000 e0", rn, d, e); end
    checks++; if (!op || !ho) begin failures++; $display("FAIL write_pulse_hold got=%b%b exp=11", op, ho); end
  endtask

  task automatic test_read();
    int bc; bit fo, rn, op, ho; logic [31:0] d; logic e;
    run_txn(1'b0, 4'hF, 32'h3000_0000, 32'h1234_5678, 1, 32'h0000_0003, bc, fo, rn, d, e, op, ho);
    checks++; if (bc !== 1 || !fo) begin failures++; $display("FAIL read_bus got=%0d/%b exp=1/1", bc, fo); end
    checks++; if (!rn || d !== 32'h0000_0003 || e !== 1'b0) begin
      failures++; $display("FAIL read_rsp got=v%b d%h e%b exp=v1 d00000003 e0", rn, d, e); end
    checks++; if (!op || !ho) begin failures++; $display("FAIL read_pulse_hold got=%b%b exp=11", op, ho); end
  endtask

  task automatic test_timeout();
    int bc, ack_on, ebc; bit fo, rn, op, ho; logic [31:0] d; logic e;
    ack_on = TO_EN ? 0 : 40;
    ebc = exp_bus_cycles(ack_on);
    run_txn(1'b0, 4'hF, 32'h3000_0FF0, 32'h0, ack_on, 32'hDEAD_BEEF, bc, fo, rn, d, e, op, ho);
    checks++; if (bc !== ebc || !fo) begin failures++; $display("FAIL timeout_bus got=%0d/%b exp=%0d/1", bc, fo, ebc); end
    checks++; if (!rn || d !== (TO_EN ? 32'h0 : 32'hDEAD_BEEF) || e !== TO_EN) begin
      failures++; $display("FAIL timeout_rsp got=v%b d%h e%b exp_err=%b", rn, d, e, TO_EN); end
    checks++; if (!op || !ho) begin failures++; $display("FAIL timeout_pulse_hold got=%b%b exp=11", op, ho); end
  endtask

  task automatic test_ack_at_timeout();
    int bc; bit fo, rn, op, ho; logic [31:0] d; logic e;
    run_txn(1'b0, 4'h3, 32'h3000_0FF0, 32'h0, TMO + 1, 32'hA5A5_A5A5, bc, fo, rn, d, e, op, ho);
    checks++; if (bc !== TMO + 1) begin failures++; $display("FAIL ack_timeout_bus got=%0d exp=%0d", bc, TMO + 1); end
    checks++; if (!rn || d !== 32'hA5A5_A5A5 || e !== 1'b0) begin
      failures++; $display("FAIL ack_timeout_rsp got=v%b d%h e%b exp=v1 da5a5a5a5 e0", rn, d, e); end
  endtask

  task automatic test_reset_mid_bus();
    int bc, k; bit fo, rn, op, ho, saw_rsp; logic [31:0] d; logic e;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0010; cmd_dat = 32'h0;
    wbm_ack_i = 1'b0;
    k = 0;
    while (!cmd_ready && k < 50) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++; if (wbm_cyc_o !== 1'b1) begin failures++; $display("FAIL rstmid_in_bus got=%b exp=1", wbm_cyc_o); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({wbm_cyc_o, wbm_stb_o} !== 2'b00) begin
      failures++; $display("FAIL rstmid_async_drop got=%b exp=00", {wbm_cyc_o, wbm_stb_o}); end
    cmd_valid = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (rsp_valid || wbm_cyc_o) saw_rsp = 1'b1;
    end
    cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    if (rsp_valid) saw_rsp = 1'b1;
    checks++; if (saw_rsp || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_no_rsp got=rsp%b ready%b exp=rsp0 ready1", saw_rsp, cmd_ready); end
    run_txn(1'b0, 4'hC, 32'h3000_0020, 32'h0, 2, 32'h0BAD_F00D, bc, fo, rn, d, e, op, ho);
    checks++; if (bc !== 2 || !fo || !rn || d !== 32'h0BAD_F00D || e !== 1'b0 || !op) begin
      failures++; $display("FAIL rstmid_after got=bc%0d f%b v%b d%h e%b p%b exp=bc2 f1 v1 d0badf00d e0 p1", bc, fo, rn, d, e, op); end
  endtask

  task automatic test_back_to_back();
    int accepts, pulses, bus_n, first_rsp, second_acc; bit prev_cyc, held, ready_in_resp;
    logic [31:0] d1, d2, adr2;
    accepts = 0; pulses = 0; bus_n = 0; first_rsp = -1; second_acc = -1;
    prev_cyc = 1'b0; held = 1'b0; ready_in_resp = 1'b0;
    d1 = 32'h0; d2 = 32'h0; adr2 = 32'h0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0100; cmd_dat = 32'h0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (wbm_cyc_o && !prev_cyc) begin
        accepts++; bus_n = 0;
        if (accepts == 1) cmd_adr = 32'h3000_0200;
        else begin cmd_valid = 1'b0; second_acc = c; adr2 = wbm_adr_o; end
      end
      if (wbm_cyc_o) bus_n++;
      if (rsp_valid) begin
        pulses++;
        if (cmd_ready) ready_in_resp = 1'b1;
        if (pulses == 1) begin first_rsp = c; d1 = rsp_dat; end else d2 = rsp_dat;
      end
      if (wbm_cyc_o && bus_n == 2) begin wbm_ack_i = 1'b1; held = 1'b1; end
      else if (held) begin wbm_ack_i = 1'b1; held = 1'b0; end
      else wbm_ack_i = 1'b0;
      wbm_dat_i = (accepts == 1) ? 32'h1111_AAAA : 32'h2222_BBBB;
      prev_cyc = wbm_cyc_o;
    end
    wbm_ack_i = 1'b0;
    cmd_valid = 1'b0;
    checks++; if (accepts !== 2 || pulses !== 2) begin
      failures++; $display("FAIL b2b_counts got=acc%0d rsp%0d exp=acc2 rsp2", accepts, pulses); end
    checks++; if (second_acc - first_rsp !== 2 || ready_in_resp) begin
      failures++; $display("FAIL b2b_spacing got=%0d rdy%b exp=2 rdy0", second_acc - first_rsp, ready_in_resp); end
    checks++; if (d1 !== 32'h1111_AAAA || d2 !== 32'h2222_BBBB || adr2 !== 32'h3000_0200) begin
      failures++; $display("FAIL b2b_data got=%h %h %h exp=1111aaaa 2222bbbb 30000200", d1, d2, adr2); end
  endtask

  task automatic test_random();
    int bc, ack_on, ebc; bit fo, rn, op, ho, acked; logic [31:0] d, adr, dat, rdata, ed; logic e, we;
    logic [3:0] sel;
    for (int n = 0; n < 24; n++) begin
      we = 1'($urandom); sel = 4'($urandom); adr = $urandom; dat = $urandom; rdata = $urandom;
      ack_on = $urandom_range(1, 7);
      ebc = exp_bus_cycles(ack_on);
      acked = (ebc == ack_on);
      ed = (acked && !we) ? rdata : 32'h0;
      run_txn(we, sel, adr, dat, ack_on, rdata, bc, fo, rn, d, e, op, ho);
      checks++; if (bc !== ebc || !fo) begin
        failures++; $display("FAIL rand%0d_bus got=%0d/%b exp=%0d/1", n, bc, fo, ebc); end
      checks++; if (!rn || d !== ed || e !== !acked) begin
        failures++; $display("FAIL rand%0d_rsp got=v%b d%h e%b exp=v1 d%h e%b", n, rn, d, e, ed, !acked); end
      checks++; if (!op || !ho) begin failures++; $display("FAIL rand%0d_pulse_hold got=%b%b exp=11", n, op, ho); end
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = 4'h0; cmd_adr = 32'h0; cmd_dat = 32'h0;
    wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_bus();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
